// File: rtl/lns_dot_accum.sv
// LNS dot-product accumulator: log-domain multiply, one-stage product register, serial LNS accumulation.
// lns_add is the shared combinational LNS adder; its corrections are 128*log2(1 +/- 2^-t) at half-unit t steps.

module lns_add (
   input  logic [11:0] x,
   input  logic [11:0] y,
   output logic [11:0] z
);
   logic               x_big;
   logic               same_sign;
   logic [10:0]        l_max;
   logic [10:0]        l_min;
   logic [11:0]        diff;
   logic signed [11:0] corr;
   logic signed [11:0] sum;
   logic [10:0]        l_res;

   assign x_big     = $signed(x[10:0]) >= $signed(y[10:0]);
   assign same_sign = x[11] == y[11];

   always_comb begin
      l_max = x_big ? x[10:0] : y[10:0];
      l_min = x_big ? y[10:0] : x[10:0];
      diff  = {l_max[10], l_max} - {l_min[10], l_min};
      corr  = '0;
      // Beyond 8 octaves apart the smaller operand no longer affects the result.
      if (diff[11:10] == 2'b00) begin
         if (same_sign) begin
            case (diff[9:6])
               4'd0:  corr = 12'sd128;
               4'd1:  corr = 12'sd99;
               4'd2:  corr = 12'sd75;
               4'd3:  corr = 12'sd56;
               4'd4:  corr = 12'sd41;
               4'd5:  corr = 12'sd30;
               4'd6:  corr = 12'sd22;
               4'd7:  corr = 12'sd16;
               4'd8:  corr = 12'sd11;
               4'd9:  corr = 12'sd8;
               4'd10: corr = 12'sd6;
               4'd11: corr = 12'sd4;
               4'd12: corr = 12'sd3;
               4'd13: corr = 12'sd2;
               4'd14: corr = 12'sd1;
               4'd15: corr = 12'sd1;
            endcase
         end else begin
            case (diff[9:6])
               4'd0:  corr = -12'sd1024;
               4'd1:  corr = -12'sd227;
               4'd2:  corr = -12'sd128;
               4'd3:  corr = -12'sd81;
               4'd4:  corr = -12'sd53;
               4'd5:  corr = -12'sd36;
               4'd6:  corr = -12'sd25;
               4'd7:  corr = -12'sd17;
               4'd8:  corr = -12'sd12;
               4'd9:  corr = -12'sd8;
               4'd10: corr = -12'sd6;
               4'd11: corr = -12'sd4;
               4'd12: corr = -12'sd3;
               4'd13: corr = -12'sd2;
               4'd14: corr = -12'sd1;
               4'd15: corr = -12'sd1;
            endcase
         end
      end
      sum = $signed({l_max[10], l_max}) + corr;
      case (sum[11:10])
         2'b01:   l_res = 11'h3FF;
         2'b10:   l_res = 11'h400;
         default: l_res = sum[10:0];
      endcase
      z = {(x_big ? x[11] : y[11]), l_res};
   end
endmodule

module lns_dot_accum #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [11:0]        in_a,
   input  logic [11:0]        in_b,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [11:0]        out_data,
   output logic [COUNT_W-1:0] out_count,
   output logic               out_sat
);
   // state | meaning
   // IDLE  | waiting for the first term of a dot product
   // ACCUM | terms streaming in, accumulator being updated
   // DRAIN | last term in stage P, folding into the accumulator
   // DONE  | result presented until the consumer takes it
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t state_q, state_d;

   logic               accept;
   logic signed [11:0] prod_sum;
   logic               prod_hi;
   logic               prod_lo;
   logic [10:0]        prod_log;
   logic [11:0]        add_z;

   logic               p_valid_q, p_valid_d;
   logic               p_last_q, p_last_d;
   logic [11:0]        p_data_q, p_data_d;
   logic [11:0]        acc_q, acc_d;
   logic               acc_empty_q, acc_empty_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic [11:0]        out_data_q, out_data_d;
   logic [COUNT_W-1:0] out_count_q, out_count_d;
   logic               out_sat_q, out_sat_d;

   assign accept   = in_valid & in_ready;
   assign prod_sum = $signed({in_a[10], in_a[10:0]}) + $signed({in_b[10], in_b[10:0]});
   assign prod_hi  = prod_sum[11:10] == 2'b01;
   assign prod_lo  = prod_sum[11:10] == 2'b10;
   assign prod_log = prod_hi ? 11'h3FF : (prod_lo ? 11'h400 : prod_sum[10:0]);

   lns_add u_add (
      .x (acc_q),
      .y (p_data_q),
      .z (add_z)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept) state_d = in_last ? DRAIN : ACCUM;
         ACCUM: if (accept && in_last) state_d = DRAIN;
         DRAIN: state_d = DONE;
         DONE:  if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = ~rst & ((state_q == IDLE) | (state_q == ACCUM));
      out_valid = state_q == DONE;
   end

   always_comb begin
      p_valid_d   = accept;
      p_last_d    = accept & in_last;
      p_data_d    = accept ? {in_a[11] ^ in_b[11], prod_log} : p_data_q;
      acc_d       = acc_q;
      acc_empty_d = acc_empty_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_sat_d   = out_sat_q;
      if (accept) begin
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         if (prod_hi | prod_lo) sat_d = 1'b1;
      end
      // No zero code in LNS, so the first product seeds the accumulator directly.
      if (p_valid_q) begin
         acc_d       = acc_empty_q ? p_data_q : add_z;
         acc_empty_d = 1'b0;
         if (p_last_q) begin
            out_data_d  = acc_d;
            out_count_d = cnt_q;
            out_sat_d   = sat_q;
            cnt_d       = '0;
            sat_d       = 1'b0;
         end
      end
      if ((state_q == DONE) && out_ready) begin
         acc_empty_d = 1'b1;
         out_count_d = '0;
         out_sat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_valid_q   <= 1'b0;
         p_last_q    <= 1'b0;
         p_data_q    <= '0;
         acc_q       <= '0;
         acc_empty_q <= 1'b1;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         p_valid_q   <= p_valid_d;
         p_last_q    <= p_last_d;
         p_data_q    <= p_data_d;
         acc_q       <= acc_d;
         acc_empty_q <= acc_empty_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_lns_dot_accum.sv
// Bench for lns_dot_accum: directed steps plus random streams, checked against a scoreboard of model results.
module tb_lns_dot_accum;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [11:0]   in_a;
   logic [11:0]   in_b;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [11:0]   out_data;
   logic [CW-1:0] out_count;
   logic          out_sat;

   always #5 clk = ~clk;

   lns_dot_accum #(.COUNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_sat   (out_sat)
   );

   typedef struct packed {
      logic [11:0]   d;
      logic [CW-1:0] c;
      logic          s;
   } res_t;

   res_t          sb_q[$];
   int            n_checks = 0;
   int            n_err = 0;
   int            n_in = 0;
   int            n_last = 0;
   int            n_out = 0;
   int            sb_tab[16];
   int            db_tab[16];
   logic [11:0]   m_acc;
   logic          m_empty;
   logic [CW-1:0] m_cnt;
   logic          m_sat;
   bit            last_acc;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rnd(real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   function automatic int clamp_l(int v);
      if (v > 1023) return 1023;
      if (v < -1024) return -1024;
      return v;
   endfunction

   function automatic logic [11:0] m_add(logic [11:0] x, logic [11:0] y);
      int lx, ly, lmax, lmin, d, c, r;
      logic s;
      logic [10:0] rl;
      lx = $signed(x[10:0]);
      ly = $signed(y[10:0]);
      if (lx >= ly) begin lmax = lx; lmin = ly; s = x[11]; end
      else          begin lmax = ly; lmin = lx; s = y[11]; end
      d = lmax - lmin;
      if (d >= 1024)          c = 0;
      else if (x[11] == y[11]) c = sb_tab[d / 64];
      else                     c = db_tab[d / 64];
      r  = clamp_l(lmax + c);
      rl = r[10:0];
      return {s, rl};
   endfunction

   task automatic model_reset();
      m_acc   = '0;
      m_empty = 1'b1;
      m_cnt   = '0;
      m_sat   = 1'b0;
   endtask

   task automatic model_beat(logic [11:0] a, logic [11:0] b, logic last);
      int l, lc;
      logic [10:0] lb;
      logic [11:0] p;
      n_in++;
      l  = $signed(a[10:0]) + $signed(b[10:0]);
      lc = clamp_l(l);
      lb = lc[10:0];
      p  = {a[11] ^ b[11], lb};
      if (lc != l) m_sat = 1'b1;
      if (m_cnt != '1) m_cnt++;
      m_acc   = m_empty ? p : m_add(m_acc, p);
      m_empty = 1'b0;
      if (last) begin
         sb_q.push_back('{d: m_acc, c: m_cnt, s: m_sat});
         n_last++;
         model_reset();
      end
   endtask

   // Handshakes are decided on the falling edge; inputs change 1 time unit after the rising edge.
   task automatic tick();
      res_t e;
      @(negedge clk);
      last_acc = in_valid && in_ready;
      if (last_acc) model_beat(in_a, in_b, in_last);
      if (out_valid && out_ready) begin
         n_out++;
         check("sb_pop_avail", 32'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_data", out_data, e.d);
            check("sb_count", out_count, e.c);
            check("sb_sat", out_sat, e.s);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(string tag);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, out_valid, 1);
   endtask

   task automatic pop_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic logic [11:0] rand_op();
      int l;
      logic [10:0] lb;
      logic s;
      l = int'($urandom_range(0, 600)) - 300;
      if ($urandom_range(0, 9) == 0) l = int'($urandom_range(0, 2047)) - 1024;
      lb = l[10:0];
      s  = 1'($urandom_range(0, 1));
      return {s, lb};
   endfunction

   initial begin
      real t, e;
      logic [11:0] held;
      int len, k, guard;

      for (int i = 0; i < 16; i++) begin
         t = i * 0.5;
         e = $pow(2.0, -t);
         sb_tab[i] = rnd(128.0 * $ln(1.0 + e) / $ln(2.0));
         db_tab[i] = (i == 0) ? -1024 : rnd(128.0 * $ln(1.0 - e) / $ln(2.0));
      end
      model_reset();
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 12'h000);
      check("rst_out_count", out_count, 0);
      check("rst_out_sat", out_sat, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 check("rdy_after_rst", in_ready, 1);

      // single term {0,128}*{0,128}
      in_valid = 1'b1; in_a = 12'h080; in_b = 12'h080; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_accept", last_acc, 1);
      check("t1_valid_edge1", out_valid, 0);
      check("t1_ready_drain", in_ready, 0);
      tick();
      check("t1_valid_edge2", out_valid, 1);
      check("t1_data", out_data, 12'h100);
      check("t1_count", out_count, 1);
      check("t1_sat", out_sat, 0);
      pop_result();
      check("t1_valid_drop", out_valid, 0);

      // two terms back to back
      in_valid = 1'b1; in_a = 12'h080; in_b = 12'h000; in_last = 1'b0;
      tick();
      in_a = 12'h000; in_b = 12'h080; in_last = 1'b1;
      tick();
      check("t2_b2b_accept", last_acc, 1);
      in_valid = 1'b0;
      wait_valid("t2");
      check("t2_data", out_data, 12'h100);
      check("t2_count", out_count, 2);
      pop_result();

      // product log saturation, high then low
      in_valid = 1'b1; in_a = 12'h3E8; in_b = 12'hBE8; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid("t3a");
      check("t3a_data", out_data, 12'hBFF);
      check("t3a_sat", out_sat, 1);
      pop_result();
      check("t3a_sat_clear", out_sat, 0);
      in_valid = 1'b1; in_a = 12'hC18; in_b = 12'hC18; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid("t3b");
      check("t3b_data", out_data, 12'h400);
      check("t3b_sat", out_sat, 1);
      pop_result();

      // backpressure with a beat offered while the result waits
      in_valid = 1'b1; in_a = 12'h040; in_b = 12'h040; in_last = 1'b1;
      tick();
      in_a = 12'h123; in_b = 12'h045;
      tick();
      held = out_data;
      check("t4_data", held, 12'h080);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold_valid", out_valid, 1);
         check("t4_hold_data", out_data, held);
         check("t4_hold_count", out_count, 1);
         check("t4_hold_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      pop_result();

      // reset in the middle of a sum
      in_valid = 1'b1; in_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a = rand_op(); in_b = rand_op();
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t5_rst_ready", in_ready, 0);
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_data", out_data, 12'h000);
      check("t5_rst_count", out_count, 0);
      model_reset();
      tick();
      rst = 1'b0;
      in_valid = 1'b1; in_a = 12'h0C0; in_b = 12'h840; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid("t5");
      check("t5_data", out_data, 12'h900);
      check("t5_count", out_count, 1);
      pop_result();

      // long stream: the count saturates at all-ones
      k = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 270; i++) begin
         in_a = rand_op(); in_b = rand_op(); in_last = (i == 269);
         tick();
         if (last_acc) k++;
      end
      in_valid = 1'b0;
      check("t6_all_accepted", k, 270);
      wait_valid("t6");
      check("t6_count_sat", out_count, 8'hFF);
      pop_result();

      // random streams with random valid/ready gaps
      for (int s = 0; s < 12; s++) begin
         len = $urandom_range(1, 300);
         k = 0;
         guard = 0;
         while (k < len && guard < 5000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = rand_op();
            in_b      = rand_op();
            in_last   = (k == len - 1);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_acc) k++;
            guard++;
         end
         check("rand_stream_done", k, len);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while ((sb_q.size() > 0 || out_valid) && guard < 50) begin
         tick();
         guard++;
      end
      check("sb_drained", sb_q.size(), 0);
      check("handshake_conserved", n_out, n_last);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
